// File: rtl/radiant_scaler_readout.sv
`default_nettype none
// ============================================================================
// Module   : radiant_scaler_readout
// Brief    : WISHBONE master that snapshots the RADIANT scaler block with a
//            fixed burst of single 32-bit reads and streams each word out on
//            a valid/ready port with a last marker.
// Revision : 1.0 - initial release
// ============================================================================
module radiant_scaler_readout #(
    parameter int          NUM_WORDS = 16,
    parameter logic [15:0] BASE_ADDR = 16'h0800,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [15:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    output logic [31:0] scal_dat_o,
    output logic        scal_valid_o,
    output logic        scal_last_o,
    input  logic        scal_ready_i,
    output logic [1:0]  frame_flags_o,
    output logic [7:0]  overrun_cnt_o
);

    // Index of the final word and the counter value on the last allowed
    // strobe cycle (the read is abandoned at the edge ending that cycle).
    localparam logic [5:0]  c_LAST_IDX = 6'(NUM_WORDS - 1);
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [31:0] c_FILL     = 32'hFFFF_FFFF;
    localparam logic [7:0]  c_OVR_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_idx;
    logic [15:0] r_tmo;
    logic [15:0] r_adr;
    logic        r_cyc;
    logic        r_busy;
    logic [31:0] r_dat;
    logic        r_valid;
    logic        r_last;
    logic [1:0]  r_flags;   // {timeout_seen, err_seen}
    logic [7:0]  r_ovr;

    logic w_resp;
    logic w_tmo_hit;
    logic w_handshake;

    // Any slave termination ends the read; retry is folded into error.
    assign w_resp      = wbm_ack_i | wbm_err_i | wbm_rty_i;
    assign w_tmo_hit   = (r_tmo == c_TMO_LAST);
    assign w_handshake = r_valid & scal_ready_i;

    // Frame sequencer: issue one read, present its word, repeat per index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_tmo   <= '0;
            r_adr   <= BASE_ADDR;
            r_cyc   <= 1'b0;
            r_busy  <= 1'b0;
            r_dat   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_flags <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_REQ;
                        r_idx   <= '0;
                        r_tmo   <= '0;
                        r_adr   <= BASE_ADDR;
                        r_flags <= '0;
                        r_cyc   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (w_resp || w_tmo_hit) begin
                        r_cyc   <= 1'b0;
                        r_valid <= 1'b1;
                        r_last  <= (r_idx == c_LAST_IDX);
                        r_state <= S_OUT;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                    // Priority ack > err > rty > timeout; a response on the
                    // timeout cycle therefore still wins.
                    if (wbm_ack_i) begin
                        r_dat <= wbm_dat_i;
                    end else if (wbm_err_i || wbm_rty_i) begin
                        r_dat      <= c_FILL;
                        r_flags[0] <= 1'b1;
                    end else if (w_tmo_hit) begin
                        r_dat      <= c_FILL;
                        r_flags[1] <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_last) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + 6'd1;
                            r_adr   <= r_adr + 16'd4;
                            r_tmo   <= '0;
                            r_cyc   <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Count start requests that arrive while a frame is in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovr <= '0;
        end else if (start_i && r_busy && (r_ovr != c_OVR_MAX)) begin
            r_ovr <= r_ovr + 8'd1;
        end
    end

    assign busy_o        = r_busy;
    assign wbm_cyc_o     = r_cyc;
    assign wbm_stb_o     = r_cyc;
    assign wbm_we_o      = 1'b0;
    assign wbm_adr_o     = r_adr;
    assign wbm_dat_o     = '0;
    assign wbm_sel_o     = 4'hF;
    assign scal_dat_o    = r_dat;
    assign scal_valid_o  = r_valid;
    assign scal_last_o   = r_last;
    assign frame_flags_o = r_flags;
    assign overrun_cnt_o = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_radiant_scaler_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_radiant_scaler_readout
// Brief    : Self-checking bench: reactive WISHBONE slave and stream sink,
//            per-frame scoreboard built from the per-word response plan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_radiant_scaler_readout;

    localparam int          NW   = 16;
    localparam int          TO   = 255;
    localparam logic [15:0] BASE = 16'h0800;

    // Response kinds for the slave plan.
    localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_NONE = 3, K_ALL = 4, K_ER = 5;

    logic        clk = 1'b0;
    logic        rst_i, start_i, busy_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [15:0] wbm_adr_o;
    logic [31:0] wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;
    logic [31:0] scal_dat_o;
    logic        scal_valid_o, scal_last_o;
    logic        scal_ready_i = 1'b1;
    logic [1:0]  frame_flags_o;
    logic [7:0]  overrun_cnt_o;

    radiant_scaler_readout #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .wbm_rty_i(wbm_rty_i), .scal_dat_o(scal_dat_o), .scal_valid_o(scal_valid_o),
        .scal_last_o(scal_last_o), .scal_ready_i(scal_ready_i),
        .frame_flags_o(frame_flags_o), .overrun_cnt_o(overrun_cnt_o)
    );

    always #5 clk = ~clk;

    // Per-word slave plan for the frame under test.
    int          kind [NW];
    int          lat  [NW];
    logic [31:0] sdat [NW];

    // Observations.
    logic [15:0] addr_q [$];
    int          run_q  [$];
    logic [31:0] got_q  [$];
    logic        last_q [$];
    int          viol;
    int          rdy_mode = 0;
    int          bp_word = 0, bp_left = 0;

    int n_cmp = 0, n_bad = 0;
    int exp_ovr = 0;

    logic        rst_seen = 1'b1;
    logic        p_cyc = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_resp = 1'b0, p_last = 1'b0;
    logic [31:0] p_dat = '0;
    int          run = 0;

    always @(posedge clk) rst_seen <= rst_i;

    // Reactive slave, stream sink and protocol monitor (one process, no races).
    initial forever begin
        int w;
        @(negedge clk);
        if (rst_seen === 1'b0) begin
            if (p_cyc && p_resp && !(wbm_cyc_o === 1'b0 && scal_valid_o === 1'b1)) viol++;
            if (p_valid && p_ready) begin
                got_q.push_back(p_dat);
                last_q.push_back(p_last);
                if (p_last) begin
                    if (busy_o !== 1'b0 || scal_valid_o !== 1'b0 || wbm_cyc_o !== 1'b0) viol++;
                end else if (wbm_cyc_o !== 1'b1 || scal_valid_o !== 1'b0) viol++;
            end else if (p_valid) begin
                if (scal_valid_o !== 1'b1 || scal_dat_o !== p_dat) viol++;
            end
        end
        if (wbm_stb_o !== wbm_cyc_o || wbm_we_o !== 1'b0 || wbm_sel_o !== 4'hF || wbm_dat_o !== 32'h0) viol++;
        if (wbm_cyc_o === 1'b1 && scal_valid_o === 1'b1) viol++;
        if (wbm_cyc_o === 1'b1 && !p_cyc) addr_q.push_back(wbm_adr_o);
        if (wbm_cyc_o === 1'b1) run++;
        else begin
            if (p_cyc) run_q.push_back(run);
            run = 0;
        end
        // slave drive
        w = addr_q.size() - 1;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
        wbm_dat_i = $urandom;
        if (wbm_cyc_o === 1'b1 && w >= 0 && w < NW && run == lat[w]) begin
            case (kind[w])
                K_ACK:  begin wbm_ack_i = 1'b1; wbm_dat_i = sdat[w]; end
                K_ERR:  wbm_err_i = 1'b1;
                K_RTY:  wbm_rty_i = 1'b1;
                K_ALL:  begin wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_rty_i = 1'b1; wbm_dat_i = sdat[w]; end
                K_ER:   begin wbm_err_i = 1'b1; wbm_rty_i = 1'b1; end
                default: ;
            endcase
        end
        // sink drive
        case (rdy_mode)
            0: scal_ready_i = 1'b1;
            1: scal_ready_i = ($urandom_range(0, 3) != 0);
            default: begin
                if (scal_valid_o === 1'b1 && got_q.size() == bp_word && bp_left > 0) begin
                    scal_ready_i = 1'b0;
                    bp_left--;
                end else scal_ready_i = 1'b1;
            end
        endcase
        p_cyc   = (wbm_cyc_o === 1'b1);
        p_valid = (scal_valid_o === 1'b1);
        p_ready = scal_ready_i;
        p_resp  = wbm_ack_i | wbm_err_i | wbm_rty_i;
        p_dat   = scal_dat_o;
        p_last  = (scal_last_o === 1'b1);
    end

    // Global safety net.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        addr_q.delete(); run_q.delete(); got_q.delete(); last_q.delete();
        viol = 0;
    endtask

    task automatic plan_fixed(input int l, input logic use_addr);
        for (int i = 0; i < NW; i++) begin
            kind[i] = K_ACK;
            lat[i]  = l;
            sdat[i] = use_addr ? {16'h0, 16'(BASE + 16'(4 * i))} : $urandom;
        end
    endtask

    task automatic plan_random();
        for (int i = 0; i < NW; i++) begin
            int r;
            r = $urandom_range(0, 9);
            kind[i] = (r <= 5) ? K_ACK : (r == 6) ? K_ERR : (r == 7) ? K_RTY : (r == 8) ? K_ALL : K_ER;
            if ($urandom_range(0, 15) == 0) kind[i] = K_NONE;
            lat[i]  = $urandom_range(1, 6);
            if (kind[i] == K_ACK && $urandom_range(0, 15) == 0) lat[i] = TO;
            sdat[i] = $urandom;
        end
    endtask

    // One full frame: start, optional overrun pulses, then scoreboard.
    task automatic run_frame(input string tag, input int pulses);
        logic [1:0]  ef;
        logic [31:0] ed;
        int          er;
        int          left;
        clear_obs();
        left = pulses;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        check({tag, " start"}, {busy_o, wbm_cyc_o, frame_flags_o, wbm_adr_o},
              {1'b1, 1'b1, 2'b00, BASE});
        for (int c = 0; c < 20000 && busy_o === 1'b1; c++) begin
            if (left > 0) begin
                start_i = 1'b1;
                left--;
                if (exp_ovr < 255) exp_ovr++;
            end else start_i = 1'b0;
            @(negedge clk);
        end
        start_i = 1'b0;
        check({tag, " done"}, busy_o, 1'b0);
        repeat (4) @(negedge clk);
        check({tag, " no_extra"}, {busy_o, 32'(addr_q.size())}, {1'b0, 32'(NW)});
        check({tag, " nwords"}, got_q.size(), NW);
        ef = 2'b00;
        for (int i = 0; i < NW; i++) begin
            ed = (kind[i] == K_ACK || kind[i] == K_ALL) ? sdat[i] : 32'hFFFF_FFFF;
            er = (kind[i] == K_NONE) ? TO : lat[i];
            if (kind[i] == K_NONE) ef[1] = 1'b1;
            if (kind[i] == K_ERR || kind[i] == K_RTY || kind[i] == K_ER) ef[0] = 1'b1;
            if (i < addr_q.size()) check($sformatf("%s adr%0d", tag, i), addr_q[i], 16'(BASE + 16'(4 * i)));
            if (i < got_q.size())  check($sformatf("%s dat%0d", tag, i), got_q[i], ed);
            if (i < last_q.size()) check($sformatf("%s last%0d", tag, i), last_q[i], (i == NW - 1));
            if (i < run_q.size())  check($sformatf("%s cyclen%0d", tag, i), run_q[i], er);
        end
        check({tag, " flags"}, frame_flags_o, ef);
        check({tag, " protocol"}, viol, 0);
        check({tag, " overrun"}, overrun_cnt_o, exp_ovr);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0;
        plan_fixed(2, 1'b1);
        repeat (3) @(negedge clk);
        check("reset ctl", {wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o, scal_valid_o, scal_last_o},
              6'b0);
        check("reset bus", {wbm_adr_o, wbm_sel_o, wbm_dat_o}, {BASE, 4'hF, 32'h0});
        check("reset out", {scal_dat_o, frame_flags_o, overrun_cnt_o}, {32'h0, 2'b00, 8'h00});
        rst_i = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal: latency 2, data equals address.
        rdy_mode = 0;
        plan_fixed(2, 1'b1);
        run_frame("nominal", 0);

        // Backpressure on word 3 for 10 cycles.
        rdy_mode = 2; bp_word = 3; bp_left = 10;
        run_frame("backpressure", 0);
        check("bp applied", bp_left, 0);
        rdy_mode = 0;

        // Timeout on word 5.
        plan_fixed(3, 1'b0);
        kind[5] = K_NONE;
        run_frame("timeout", 0);

        // Error on word 0, flags held, then a clean frame.
        plan_fixed(1, 1'b0);
        kind[0] = K_ERR;
        run_frame("error", 0);
        repeat (5) @(negedge clk);
        check("flags held", frame_flags_o, 2'b01);
        plan_fixed(4, 1'b0);
        run_frame("recovery", 0);

        // Randomized frames with random backpressure.
        rdy_mode = 1;
        for (int f = 0; f < 4; f++) begin
            plan_random();
            run_frame($sformatf("random%0d", f), 0);
        end
        rdy_mode = 0;

        // Overrun: 3 pulses, then 300 pulses saturating at 255.
        plan_fixed(3, 1'b0);
        run_frame("overrun3", 3);
        for (int i = 0; i < NW; i++) kind[i] = K_NONE;
        run_frame("overrun300", 300);

        // Reset mid-read on word 7.
        plan_fixed(2, 1'b0);
        kind[7] = K_NONE;
        clear_obs();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int c = 0; c < 2000 && addr_q.size() < 8; c++) @(negedge clk);
        check("rst reached w7", {wbm_cyc_o, 32'(addr_q.size())}, {1'b1, 32'd8});
        rst_i = 1'b1;
        @(negedge clk); rst_i = 1'b0;
        check("rst mid", {wbm_cyc_o, wbm_stb_o, scal_valid_o, busy_o, overrun_cnt_o},
              {4'b0000, 8'h00});
        exp_ovr = 0;
        repeat (3) @(negedge clk);
        check("rst idle", {busy_o, wbm_cyc_o, wbm_adr_o}, {1'b0, 1'b0, BASE});
        plan_fixed(2, 1'b1);
        run_frame("after_rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
